// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: widths, control
// polarities, fetch FSM encodings and an address helper.
package if_fetch_pkg;

    localparam int AddrLen = 32;
    localparam int InstLen = 32;

    localparam logic [InstLen-1:0] ZERO_WORD = '0;

    localparam logic ResetEnable  = 1'b1;
    localparam logic StallDisable = 1'b0;
    localparam logic JumpEnable   = 1'b1;

    localparam logic [1:0] FETCH_IDLE = 2'd0;
    localparam logic [1:0] FETCH_MISS = 2'd1;
    localparam logic [1:0] FETCH_DROP = 2'd2;

    // Memory requests are always for whole words.
    function automatic logic [AddrLen-1:0] word_align(input logic [AddrLen-1:0] a);
        return {a[AddrLen-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Fetch-stage bus: PC request side, memory-controller side and IF/ID side.
interface if_fetch_if;
    import if_fetch_pkg::*;

    logic               enable_pc_i;
    logic [AddrLen-1:0] pc_i;
    logic               flush_i;
    logic               mem_req_o;
    logic [AddrLen-1:0] mem_addr_o;
    logic               mem_done_i;
    logic [InstLen-1:0] mem_inst_i;
    logic [InstLen-1:0] inst_o;
    logic [AddrLen-1:0] inst_pc_o;
    logic               inst_valid_o;
    logic               stall_req_o;

    // Fetch stage side.
    modport slave (
        input  enable_pc_i, pc_i, flush_i, mem_done_i, mem_inst_i,
        output mem_req_o, mem_addr_o, inst_o, inst_pc_o, inst_valid_o, stall_req_o
    );

    // Environment side (PC register, memory controller, IF/ID).
    modport master (
        output enable_pc_i, pc_i, flush_i, mem_done_i, mem_inst_i,
        input  mem_req_o, mem_addr_o, inst_o, inst_pc_o, inst_valid_o, stall_req_o
    );

endinterface

// File: rtl/if_fetch_icache_dm.sv
// Direct-mapped, one-word-per-line instruction cache: combinational lookup,
// single synchronous write port, valid bits cleared by reset.
module if_fetch_icache_dm
    import if_fetch_pkg::*;
#(
    parameter int ICACHE_IDX_W = 7,
    localparam int TAG_W = AddrLen - 2 - ICACHE_IDX_W,
    localparam int LINES = 1 << ICACHE_IDX_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ICACHE_IDX_W-1:0] rd_idx,
    input  logic [TAG_W-1:0]        rd_tag,
    output logic                    hit,
    output logic [InstLen-1:0]      rd_data,
    input  logic                    we,
    input  logic [ICACHE_IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0]        wr_tag,
    input  logic [InstLen-1:0]      wr_data
);

    logic [LINES-1:0]   valid_q;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [InstLen-1:0] data_q [LINES];

    // Valid bits: cleared on reset, set when a line is filled.
    always_ff @(posedge clk) begin
        if (rst == ResetEnable) begin
            valid_q <= '0;
        end else if (we) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Tag and data storage; contents are meaningless until the valid bit is set.
    always_ff @(posedge clk) begin
        if (we) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data;
        end
    end

    // Lookup reads the stored contents only; a same-cycle fill is not bypassed.
    always_comb begin
        hit     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
        rd_data = data_q[rd_idx];
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: I-cache lookup on each PC request, miss handling
// through the memory controller, and flush of in-flight fetches on redirect.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int ICACHE_IDX_W = 7,
    localparam int TAG_W = AddrLen - 2 - ICACHE_IDX_W
) (
    input  logic       clk,
    input  logic       rst,
    if_fetch_if.slave  bus
);

    logic [1:0]         state;
    logic [AddrLen-1:0] miss_pc;
    logic               mem_req_p1;
    logic [AddrLen-1:0] mem_addr_p1;
    logic               stall_p1;
    logic [InstLen-1:0] inst_p1;
    logic [AddrLen-1:0] inst_pc_p1;
    logic               vld_p1;

    logic               hit;
    logic [InstLen-1:0] hit_data;
    logic               fill_we;

    if_fetch_icache_dm #(.ICACHE_IDX_W(ICACHE_IDX_W)) u_icache (
        .clk     (clk),
        .rst     (rst),
        .rd_idx  (bus.pc_i[ICACHE_IDX_W+1:2]),
        .rd_tag  (bus.pc_i[AddrLen-1:ICACHE_IDX_W+2]),
        .hit     (hit),
        .rd_data (hit_data),
        .we      (fill_we),
        .wr_idx  (miss_pc[ICACHE_IDX_W+1:2]),
        .wr_tag  (miss_pc[AddrLen-1:ICACHE_IDX_W+2]),
        .wr_data (bus.mem_inst_i)
    );

    // Fill the line whenever the outstanding word returns, even if it was flushed.
    always_comb begin
        fill_we = ((state == FETCH_MISS) || (state == FETCH_DROP)) && bus.mem_done_i;
    end

    // Fetch FSM plus request and IF/ID output registers.
    always_ff @(posedge clk) begin
        if (rst == ResetEnable) begin
            state       <= FETCH_IDLE;
            miss_pc     <= '0;
            mem_req_p1  <= 1'b0;
            mem_addr_p1 <= '0;
            stall_p1    <= StallDisable;
            inst_p1     <= ZERO_WORD;
            inst_pc_p1  <= '0;
            vld_p1      <= 1'b0;
        end else begin
            vld_p1 <= 1'b0;
            case (state)
                FETCH_IDLE: begin
                    // A redirect this cycle makes the current PC stale: no output, no miss.
                    if (bus.enable_pc_i && (bus.flush_i != JumpEnable)) begin
                        if (hit) begin
                            vld_p1     <= 1'b1;
                            inst_p1    <= hit_data;
                            inst_pc_p1 <= bus.pc_i;
                        end else begin
                            miss_pc     <= bus.pc_i;
                            mem_req_p1  <= 1'b1;
                            mem_addr_p1 <= word_align(bus.pc_i);
                            stall_p1    <= ~StallDisable;
                            state       <= FETCH_MISS;
                        end
                    end
                end
                FETCH_MISS: begin
                    if (bus.mem_done_i) begin
                        mem_req_p1 <= 1'b0;
                        stall_p1   <= StallDisable;
                        state      <= FETCH_IDLE;
                        if (bus.flush_i != JumpEnable) begin
                            vld_p1     <= 1'b1;
                            inst_p1    <= bus.mem_inst_i;
                            inst_pc_p1 <= miss_pc;
                        end
                    end else if (bus.flush_i == JumpEnable) begin
                        // The controller cannot abort, so keep requesting and stalling.
                        state <= FETCH_DROP;
                    end
                end
                FETCH_DROP: begin
                    if (bus.mem_done_i) begin
                        mem_req_p1 <= 1'b0;
                        stall_p1   <= StallDisable;
                        state      <= FETCH_IDLE;
                    end
                end
                default: begin
                    state <= FETCH_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_req_o    = mem_req_p1;
    assign bus.mem_addr_o   = mem_addr_p1;
    assign bus.stall_req_o  = stall_p1;
    assign bus.inst_o       = inst_p1;
    assign bus.inst_pc_o    = inst_pc_p1;
    assign bus.inst_valid_o = vld_p1;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch with a scoreboard monitor on the IF/ID output.
module tb_if_fetch;
    import if_fetch_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [63:0] exp_q[$];

    if_fetch_if bus();

    if_fetch #(.ICACHE_IDX_W(7)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every delivered instruction must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bus.inst_valid_o === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_inst actual pc=%h inst=%h required=no_output",
                         bus.inst_pc_o, bus.inst_o);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({bus.inst_o, bus.inst_pc_o} !== e) begin
                    errors++;
                    $display("FAIL sb_inst actual inst=%h pc=%h required inst=%h pc=%h",
                             bus.inst_o, bus.inst_pc_o, e[63:32], e[31:0]);
                end
            end
        end
    end

    // Miss with the word returned on the delay-th MISS cycle; optional flush on cycle flush_at.
    task automatic cold_miss(input logic [31:0] addr, input logic [31:0] word,
                             input int flush_at, input int delay);
        if (flush_at < 0) exp_q.push_back({word, addr});
        bus.pc_i        = addr;
        bus.enable_pc_i = 1'b1;
        step();
        bus.enable_pc_i = 1'b0;
        for (int k = 0; k < delay; k++) begin
            @(negedge clk);
            chk("miss_req",   {31'b0, bus.mem_req_o}, 32'd1);
            chk("miss_addr",  bus.mem_addr_o, {addr[31:2], 2'b00});
            chk("miss_stall", {31'b0, bus.stall_req_o}, 32'd1);
            if (k == flush_at) bus.flush_i = 1'b1;
            if (k == delay - 1) begin
                bus.mem_done_i = 1'b1;
                bus.mem_inst_i = word;
            end
            step();
            bus.flush_i    = 1'b0;
            bus.mem_done_i = 1'b0;
        end
        @(negedge clk);
        chk("done_req",   {31'b0, bus.mem_req_o}, 32'd0);
        chk("done_stall", {31'b0, bus.stall_req_o}, 32'd0);
        chk("done_valid", {31'b0, bus.inst_valid_o}, (flush_at < 0) ? 32'd1 : 32'd0);
    endtask

    task automatic hit_fetch(input logic [31:0] addr, input logic [31:0] word);
        exp_q.push_back({word, addr});
        bus.pc_i        = addr;
        bus.enable_pc_i = 1'b1;
        step();
        bus.enable_pc_i = 1'b0;
        @(negedge clk);
        chk("hit_valid", {31'b0, bus.inst_valid_o}, 32'd1);
        chk("hit_req",   {31'b0, bus.mem_req_o}, 32'd0);
        chk("hit_stall", {31'b0, bus.stall_req_o}, 32'd0);
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        rst             = 1'b1;
        bus.pc_i        = '0;
        bus.enable_pc_i = 1'b0;
        bus.flush_i     = 1'b0;
        bus.mem_done_i  = 1'b0;
        bus.mem_inst_i  = '0;
        step();
        step();
        @(negedge clk);
        chk("rst_req",     {31'b0, bus.mem_req_o}, 32'd0);
        chk("rst_addr",    bus.mem_addr_o, 32'h0);
        chk("rst_inst",    bus.inst_o, 32'h0);
        chk("rst_pc",      bus.inst_pc_o, 32'h0);
        chk("rst_valid",   {31'b0, bus.inst_valid_o}, 32'd0);
        chk("rst_stall",   {31'b0, bus.stall_req_o}, 32'd0);
        rst = 1'b0;

        // Cold fetch, then re-fetch hits.
        cold_miss(32'h0000_0000, 32'h0000_0013, -1, 3);
        hit_fetch(32'h0000_0000, 32'h0000_0013);

        // Same index, different tag: conflict evicts in both directions.
        cold_miss(32'h0000_0200, 32'hAAAA_0001, -1, 2);
        cold_miss(32'h0000_0000, 32'h0000_0013, -1, 2);

        // Flush in the first MISS cycle: no output, but the line is filled.
        cold_miss(32'h0000_0010, 32'h0010_0093, 0, 3);
        hit_fetch(32'h0000_0010, 32'h0010_0093);

        // Flush coinciding with the returning word.
        cold_miss(32'h0000_0014, 32'h0020_0113, 1, 2);
        hit_fetch(32'h0000_0014, 32'h0020_0113);

        // Flush in IDLE suppresses a hit.
        bus.pc_i        = 32'h0000_0010;
        bus.enable_pc_i = 1'b1;
        bus.flush_i     = 1'b1;
        step();
        bus.enable_pc_i = 1'b0;
        bus.flush_i     = 1'b0;
        @(negedge clk);
        chk("idle_flush_valid", {31'b0, bus.inst_valid_o}, 32'd0);
        chk("idle_flush_req",   {31'b0, bus.mem_req_o}, 32'd0);

        // Back-to-back hits at 0x0, 0x4, 0x8.
        cold_miss(32'h0000_0004, 32'h0030_0193, -1, 1);
        cold_miss(32'h0000_0008, 32'h0040_0213, -1, 1);
        exp_q.push_back({32'h0000_0013, 32'h0000_0000});
        exp_q.push_back({32'h0030_0193, 32'h0000_0004});
        exp_q.push_back({32'h0040_0213, 32'h0000_0008});
        bus.enable_pc_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.pc_i = 32'(i * 4);
            step();
            @(negedge clk);
            chk("b2b_valid", {31'b0, bus.inst_valid_o}, 32'd1);
            chk("b2b_pc",    bus.inst_pc_o, 32'(i * 4));
        end
        bus.enable_pc_i = 1'b0;

        // Reset in the middle of a miss, then a stray completion.
        bus.pc_i        = 32'h0000_0040;
        bus.enable_pc_i = 1'b1;
        step();
        bus.enable_pc_i = 1'b0;
        @(negedge clk);
        chk("pre_rst_req", {31'b0, bus.mem_req_o}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_req",   {31'b0, bus.mem_req_o}, 32'd0);
        chk("mid_rst_stall", {31'b0, bus.stall_req_o}, 32'd0);
        bus.mem_done_i = 1'b1;
        bus.mem_inst_i = 32'hDEAD_BEEF;
        step();
        bus.mem_done_i = 1'b0;
        @(negedge clk);
        chk("stray_done_valid", {31'b0, bus.inst_valid_o}, 32'd0);
        chk("stray_done_req",   {31'b0, bus.mem_req_o}, 32'd0);

        // All lines were invalidated: previously cached words miss again.
        cold_miss(32'h0000_0000, 32'h0000_0013, -1, 2);
        cold_miss(32'h0000_0010, 32'h0010_0093, -1, 1);

        step();
        step();
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
